// File: rtl/gm_pkg.sv
// Shared codes and helpers for the player-vs-player tic-tac-toe match engine.
// Cell, round-status and FSM encodings plus the cursor navigation rule.
package gm_pkg;

   typedef enum logic [1:0] {
      ONGOING = 2'b00,
      X_WIN   = 2'b01,
      O_WIN   = 2'b10,
      DRAW    = 2'b11
   } status_t;

   typedef enum logic [1:0] {
      EMPTY  = 2'b00,
      MARK_X = 2'b01,
      MARK_O = 2'b10
   } cell_t;

   typedef enum logic [1:0] {
      PLAY       = 2'd0,
      CHECK      = 2'd1,
      ROUND_OVER = 2'd2,
      MATCH_OVER = 2'd3
   } state_t;

   localparam logic [3:0] CURSOR_HOME = 4'd4;

   // Only the highest-priority pulse moves the cursor; wraps stay inside the row/column.
   function automatic logic [3:0] cursor_step(input logic [3:0] cur, input logic up,
                                              input logic down, input logic left,
                                              input logic right);
      logic [3:0] col;
      logic [3:0] nxt;
      col = cur % 4'd3;
      nxt = cur;
      if (up)
         nxt = (cur < 4'd3) ? cur + 4'd6 : cur - 4'd3;
      else if (down)
         nxt = (cur >= 4'd6) ? cur - 4'd6 : cur + 4'd3;
      else if (left)
         nxt = (col == 4'd0) ? cur + 4'd2 : cur - 4'd1;
      else if (right)
         nxt = (col == 4'd2) ? cur - 4'd2 : cur + 4'd1;
      return nxt;
   endfunction

endpackage

// File: rtl/grid_line_checker.sv
// Combinational board evaluation: three-in-a-row for either mark, and board-full.
module grid_line_checker
   import gm_pkg::*;
(
   input  logic [17:0] board,
   output logic        x_win,
   output logic        o_win,
   output logic        full
);

   function automatic logic line_of(input logic [17:0] b, input int unsigned a,
                                    input int unsigned c, input int unsigned d,
                                    input cell_t m);
      return (b[2*a +: 2] == m) && (b[2*c +: 2] == m) && (b[2*d +: 2] == m);
   endfunction

   function automatic logic any_line(input logic [17:0] b, input cell_t m);
      return line_of(b, 0, 1, 2, m) | line_of(b, 3, 4, 5, m) | line_of(b, 6, 7, 8, m) |
             line_of(b, 0, 3, 6, m) | line_of(b, 1, 4, 7, m) | line_of(b, 2, 5, 8, m) |
             line_of(b, 0, 4, 8, m) | line_of(b, 2, 4, 6, m);
   endfunction

   always_comb begin
      x_win = any_line(board, MARK_X);
      o_win = any_line(board, MARK_O);
      full  = 1'b1;
      for (int unsigned i = 0; i < 9; i++) begin
         if (board[2*i +: 2] == EMPTY) full = 1'b0;
      end
   end

endmodule

// File: rtl/pvp_match_engine.sv
// Two-player tic-tac-toe match controller: cursor/placement, round evaluation,
// score keeping and best-of match resolution.
module pvp_match_engine
   import gm_pkg::*;
#(
   parameter int unsigned WIN_TARGET = 3,
   parameter int unsigned MAX_ROUNDS = 5
) (
   input  logic        clk,
   input  logic        general_reset,
   input  logic        grid_reset_flag,
   input  logic        enable,
   input  logic        mv_up,
   input  logic        mv_down,
   input  logic        mv_left,
   input  logic        mv_right,
   input  logic        place,
   output logic [17:0] board,
   output logic [3:0]  cursor,
   output logic        turn,
   output logic [2:0]  score_x,
   output logic [2:0]  score_o,
   output logic [1:0]  pvp_game_status,
   output logic [1:0]  pvp_game_status_final
);

   localparam logic [2:0] LP_WIN    = 3'(WIN_TARGET);
   localparam logic [3:0] LP_ROUNDS = 4'(MAX_ROUNDS);

   state_t      r_state, w_next_state;
   logic [17:0] r_board;
   logic [3:0]  r_cursor;
   logic        r_turn, r_starter;
   logic [2:0]  r_score_x, r_score_o;
   logic [3:0]  r_rounds;
   status_t     r_status, r_final;

   logic        w_x_win, w_o_win, w_full;
   logic        w_cursor_empty, w_place_ok, w_grid_clear;
   logic        w_win, w_round_end, w_target_hit, w_match_end;
   logic [2:0]  w_sx_next, w_so_next;
   logic [3:0]  w_rounds_next;
   cell_t       w_mark;
   status_t     w_final;

   grid_line_checker u_checker (
      .board (r_board),
      .x_win (w_x_win),
      .o_win (w_o_win),
      .full  (w_full)
   );

   always_comb begin
      w_cursor_empty = 1'b0;
      for (int unsigned i = 0; i < 9; i++) begin
         if (r_cursor == 4'(i)) w_cursor_empty = (r_board[2*i +: 2] == EMPTY);
      end
      w_mark        = r_turn ? MARK_O : MARK_X;
      w_grid_clear  = grid_reset_flag && (r_state != MATCH_OVER);
      w_place_ok    = (r_state == PLAY) && enable && place && w_cursor_empty;
      // Only the player who just moved can have completed a line.
      w_win         = r_turn ? w_o_win : w_x_win;
      w_round_end   = (r_state == CHECK) && (w_win || w_full);
      w_sx_next     = (w_win && !r_turn && r_score_x < LP_WIN) ? r_score_x + 3'd1 : r_score_x;
      w_so_next     = (w_win &&  r_turn && r_score_o < LP_WIN) ? r_score_o + 3'd1 : r_score_o;
      w_rounds_next = (r_rounds < LP_ROUNDS) ? r_rounds + 4'd1 : r_rounds;
      w_target_hit  = w_win && ((r_turn ? w_so_next : w_sx_next) == LP_WIN);
      w_match_end   = w_round_end && (w_target_hit || (w_rounds_next == LP_ROUNDS));
      if (w_target_hit)             w_final = r_turn ? O_WIN : X_WIN;
      else if (w_sx_next > w_so_next) w_final = X_WIN;
      else if (w_so_next > w_sx_next) w_final = O_WIN;
      else                          w_final = DRAW;
   end

   always_ff @(posedge clk) begin
      if (general_reset) r_state <= PLAY;
      else               r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      if (w_grid_clear) begin
         w_next_state = PLAY;
      end else begin
         case (r_state)
            PLAY:    if (w_place_ok) w_next_state = CHECK;
            CHECK: begin
               if (w_match_end)      w_next_state = MATCH_OVER;
               else if (w_round_end) w_next_state = ROUND_OVER;
               else                  w_next_state = PLAY;
            end
            default: w_next_state = r_state;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (general_reset) begin
         r_board   <= '0;
         r_cursor  <= CURSOR_HOME;
         r_turn    <= 1'b0;
         r_starter <= 1'b0;
         r_score_x <= '0;
         r_score_o <= '0;
         r_rounds  <= '0;
         r_status  <= ONGOING;
         r_final   <= ONGOING;
      end else if (w_grid_clear) begin
         r_board  <= '0;
         r_cursor <= CURSOR_HOME;
         r_status <= ONGOING;
         // Starter alternates once per finished round; later cycles see ONGOING.
         if (r_status != ONGOING) begin
            r_starter <= ~r_starter;
            r_turn    <= ~r_starter;
         end else begin
            r_turn <= r_starter;
         end
      end else if (r_state == PLAY) begin
         if (w_place_ok) begin
            for (int unsigned i = 0; i < 9; i++) begin
               if (r_cursor == 4'(i)) r_board[2*i +: 2] <= w_mark;
            end
         end else if (enable && !place) begin
            r_cursor <= cursor_step(r_cursor, mv_up, mv_down, mv_left, mv_right);
         end
      end else if (r_state == CHECK) begin
         if (w_round_end) begin
            r_status  <= w_win ? (r_turn ? O_WIN : X_WIN) : DRAW;
            r_score_x <= w_sx_next;
            r_score_o <= w_so_next;
            r_rounds  <= w_rounds_next;
            if (w_match_end) r_final <= w_final;
         end else begin
            r_turn <= ~r_turn;
         end
      end
   end

   always_comb begin
      board                 = r_board;
      cursor                = r_cursor;
      turn                  = r_turn;
      score_x               = r_score_x;
      score_o               = r_score_o;
      pvp_game_status       = r_status;
      pvp_game_status_final = r_final;
   end

endmodule

// File: tb/tb_pvp_match_engine.sv
// Scoreboard bench for pvp_match_engine: directed games with hand-derived results.
module tb_pvp_match_engine;

   logic        clk = 1'b0;
   logic        general_reset = 1'b1, grid_reset_flag = 1'b0, enable = 1'b1;
   logic        mv_up = 1'b0, mv_down = 1'b0, mv_left = 1'b0, mv_right = 1'b0, place = 1'b0;
   logic [17:0] board;
   logic [3:0]  cursor;
   logic        turn;
   logic [2:0]  score_x, score_o;
   logic [1:0]  pvp_game_status, pvp_game_status_final;

   always #5 clk = ~clk;

   pvp_match_engine #(.WIN_TARGET(3), .MAX_ROUNDS(5)) dut (
      .clk                   (clk),
      .general_reset         (general_reset),
      .grid_reset_flag       (grid_reset_flag),
      .enable                (enable),
      .mv_up                 (mv_up),
      .mv_down               (mv_down),
      .mv_left               (mv_left),
      .mv_right              (mv_right),
      .place                 (place),
      .board                 (board),
      .cursor                (cursor),
      .turn                  (turn),
      .score_x               (score_x),
      .score_o               (score_o),
      .pvp_game_status       (pvp_game_status),
      .pvp_game_status_final (pvp_game_status_final)
   );

   typedef enum int {S_BOARD, S_CURSOR, S_TURN, S_SX, S_SO, S_STAT, S_FINAL} sig_t;
   typedef struct {
      sig_t        sig;
      logic [17:0] exp;
      string       tag;
   } chk_t;

   chk_t q[$];
   int   checks = 0;
   int   errors = 0;

   int   bm[9];
   int   cur;
   logic tm, sm;

   function automatic logic [17:0] observe(input sig_t s);
      case (s)
         S_BOARD:  return board;
         S_CURSOR: return 18'(cursor);
         S_TURN:   return 18'(turn);
         S_SX:     return 18'(score_x);
         S_SO:     return 18'(score_o);
         S_STAT:   return 18'(pvp_game_status);
         default:  return 18'(pvp_game_status_final);
      endcase
   endfunction

   // Monitor: drains the expectation queue against what the DUT shows mid-cycle.
   always @(negedge clk) begin
      while (q.size() > 0) begin
         chk_t c;
         logic [17:0] act;
         c   = q.pop_front();
         act = observe(c.sig);
         checks++;
         if (act !== c.exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", c.tag, act, c.exp);
         end
      end
   end

   function automatic logic [17:0] pack();
      logic [17:0] b;
      b = '0;
      for (int i = 0; i < 9; i++) b[2*i +: 2] = 2'(bm[i]);
      return b;
   endfunction

   task automatic expect_(input sig_t s, input logic [17:0] e, input string tag);
      chk_t c;
      c.sig = s; c.exp = e; c.tag = tag;
      q.push_back(c);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mvs(input logic [3:0] m);
      {mv_up, mv_down, mv_left, mv_right} = m;
      tick();
      {mv_up, mv_down, mv_left, mv_right} = 4'b0;
   endtask

   task automatic goto(input int t);
      while (cur % 3 != t % 3) begin
         mvs(4'b0001);
         cur = (cur / 3) * 3 + (cur % 3 + 1) % 3;
      end
      while (cur / 3 != t / 3) begin
         mvs(4'b0100);
         cur = (cur + 3) % 9;
      end
   endtask

   task automatic place_at(input int t, input bit ends);
      goto(t);
      place = 1'b1;
      tick();
      place = 1'b0;
      bm[t] = tm ? 2 : 1;
      expect_(S_STAT, 18'd0, "stat_before_check");
      expect_(S_BOARD, pack(), "board_after_place");
      tick();
      if (!ends) tm = ~tm;
      expect_(S_TURN, 18'(tm), "turn_after_check");
   endtask

   task automatic do_reset();
      general_reset = 1'b1;
      tick();
      general_reset = 1'b0;
      for (int i = 0; i < 9; i++) bm[i] = 0;
      cur = 4; tm = 1'b0; sm = 1'b0;
   endtask

   task automatic grid_clear(input int n);
      grid_reset_flag = 1'b1;
      repeat (n) tick();
      grid_reset_flag = 1'b0;
      for (int i = 0; i < 9; i++) bm[i] = 0;
      cur = 4; sm = ~sm; tm = sm;
   endtask

   int draw_seq[9] = '{0, 2, 1, 3, 5, 4, 6, 7, 8};
   int xwin_seq[5] = '{0, 3, 1, 4, 2};
   int xwin_o_first[6] = '{6, 0, 7, 1, 5, 2};

   initial begin
      do_reset();
      expect_(S_BOARD, 18'd0, "rst_board");
      expect_(S_CURSOR, 18'd4, "rst_cursor");
      expect_(S_TURN, 18'd0, "rst_turn");
      expect_(S_SX, 18'd0, "rst_score_x");
      expect_(S_SO, 18'd0, "rst_score_o");
      expect_(S_STAT, 18'd0, "rst_status");
      expect_(S_FINAL, 18'd0, "rst_final");

      // X takes the top row
      for (int k = 0; k < 5; k++) place_at(xwin_seq[k], k == 4);
      expect_(S_STAT, 18'd1, "row_win_status");
      expect_(S_SX, 18'd1, "row_win_score_x");
      expect_(S_TURN, 18'd0, "row_win_turn_kept");

      // placing on an occupied cell is ignored and the FSM stays in PLAY
      do_reset();
      place_at(0, 1'b0);
      place = 1'b1; tick(); place = 1'b0; tick();
      expect_(S_BOARD, 18'h00001, "occupied_board");
      expect_(S_TURN, 18'd1, "occupied_turn");
      mvs(4'b0001);
      expect_(S_CURSOR, 18'd1, "occupied_still_play");

      // cursor wraps and move/place priority
      do_reset();
      goto(2);
      mvs(4'b0001); cur = 0;
      expect_(S_CURSOR, 18'd0, "right_wrap");
      goto(1);
      mvs(4'b1000); cur = 7;
      expect_(S_CURSOR, 18'd7, "up_wrap");
      mv_up = 1'b1; place = 1'b1; tick(); mv_up = 1'b0; place = 1'b0; tick();
      bm[7] = 1;
      expect_(S_BOARD, pack(), "place_beats_move_board");
      expect_(S_CURSOR, 18'd7, "place_beats_move_cursor");
      expect_(S_TURN, 18'd1, "place_beats_move_turn");
      mvs(4'b1100); expect_(S_CURSOR, 18'd4, "up_over_down");
      mvs(4'b0111); expect_(S_CURSOR, 18'd7, "down_over_left_right");
      mvs(4'b0011); expect_(S_CURSOR, 18'd6, "left_over_right");
      mvs(4'b0010); expect_(S_CURSOR, 18'd8, "left_wrap");
      mvs(4'b0001); expect_(S_CURSOR, 18'd6, "right_wrap_row2");
      mvs(4'b0100); expect_(S_CURSOR, 18'd0, "down_wrap");
      enable = 1'b0;
      mvs(4'b0001);
      place = 1'b1; tick(); place = 1'b0; tick();
      enable = 1'b1;
      expect_(S_CURSOR, 18'd0, "disabled_move");
      expect_(S_BOARD, pack(), "disabled_place");

      // O completes the middle row; ROUND_OVER ignores inputs
      do_reset();
      place_at(0, 1'b0); place_at(3, 1'b0); place_at(1, 1'b0);
      place_at(4, 1'b0); place_at(8, 1'b0); place_at(5, 1'b1);
      expect_(S_STAT, 18'd2, "o_win_status");
      expect_(S_SO, 18'd1, "o_win_score_o");
      expect_(S_SX, 18'd0, "o_win_score_x");
      expect_(S_TURN, 18'd1, "o_win_turn");
      mvs(4'b0001);
      expect_(S_CURSOR, 18'd5, "round_over_move_ignored");

      // reset landing on the CHECK edge of a winning place
      do_reset();
      place_at(0, 1'b0); place_at(3, 1'b0); place_at(1, 1'b0); place_at(4, 1'b0);
      goto(2);
      place = 1'b1; tick(); place = 1'b0;
      general_reset = 1'b1; tick(); general_reset = 1'b0;
      for (int i = 0; i < 9; i++) bm[i] = 0;
      cur = 4; tm = 1'b0;
      tick();
      expect_(S_STAT, 18'd0, "reset_in_check_status");
      expect_(S_SX, 18'd0, "reset_in_check_score");
      expect_(S_BOARD, 18'd0, "reset_in_check_board");

      // five drawn rounds end the match as a tie
      do_reset();
      for (int r = 1; r <= 5; r++) begin
         for (int k = 0; k < 9; k++) place_at(draw_seq[k], k == 8);
         expect_(S_STAT, 18'd3, "draw_status");
         expect_(S_SX, 18'd0, "draw_score_x");
         expect_(S_SO, 18'd0, "draw_score_o");
         expect_(S_FINAL, (r == 5) ? 18'd3 : 18'd0, "draw_final");
         if (r < 5) begin
            grid_clear((r == 1) ? 10 : 2);
            expect_(S_BOARD, 18'd0, "clear_board");
            expect_(S_STAT, 18'd0, "clear_status");
            expect_(S_TURN, 18'(tm), "clear_turn_starter");
            expect_(S_CURSOR, 18'd4, "clear_cursor");
         end
      end
      grid_reset_flag = 1'b1; repeat (3) tick(); grid_reset_flag = 1'b0;
      expect_(S_BOARD, pack(), "match_over_board_held");
      expect_(S_FINAL, 18'd3, "match_over_final_held");

      // X reaches the win target in three rounds
      do_reset();
      for (int k = 0; k < 5; k++) place_at(xwin_seq[k], k == 4);
      grid_clear(3);
      expect_(S_TURN, 18'd1, "round2_starter_o");
      for (int k = 0; k < 6; k++) place_at(xwin_o_first[k], k == 5);
      expect_(S_SX, 18'd2, "round2_score_x");
      expect_(S_FINAL, 18'd0, "round2_final");
      grid_clear(3);
      for (int k = 0; k < 5; k++) place_at(xwin_seq[k], k == 4);
      expect_(S_SX, 18'd3, "round3_score_x");
      expect_(S_FINAL, 18'd1, "round3_final");
      grid_reset_flag = 1'b1; repeat (3) tick(); grid_reset_flag = 1'b0;
      expect_(S_BOARD, pack(), "final_board_held");
      expect_(S_FINAL, 18'd1, "final_held");
      expect_(S_STAT, 18'd1, "final_status_held");

      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
      #2;
      if (q.size() > 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1);
   end

endmodule
